// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================
// Package  : regfile_pkg
// Brief    : Shared sizes and helpers for the register file path
// Revision : 1.0 - initial release
// ============================================================
package regfile_pkg;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 32;

  localparam logic [AW-1:0] C_REG_ZERO = '0;

  function automatic logic [NREG-1:0] reg_onehot(input logic [AW-1:0] r);
    return NREG'(1) << r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================
// Module   : rr_arbiter
// Brief    : NREQ-wide round-robin grant with pointer update
// Revision : 1.0 - initial release
// ============================================================
module rr_arbiter #(
  parameter int NREQ = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NREQ-1:0] valid_i,
  output logic [NREQ-1:0] grant_o,
  output logic            xfer_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   ptr_d;
  logic [PW-1:0]   win;
  logic [NREQ-1:0] grant;
  logic            found;

  // Two passes: indices at/above the pointer first, then the wrapped-around ones.
  always_comb begin
    grant = '0;
    found = 1'b0;
    win   = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!found && (j >= int'(ptr_q)) && valid_i[j]) begin
        grant[j] = 1'b1;
        found    = 1'b1;
        win      = PW'(j);
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!found && (j < int'(ptr_q)) && valid_i[j]) begin
        grant[j] = 1'b1;
        found    = 1'b1;
        win      = PW'(j);
      end
    end
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign grant_o = grant;
  assign xfer_o  = found;

endmodule
`default_nettype wire

// File: rtl/regfile_wb_ctrl.sv
`default_nettype none
// ============================================================
// Module   : regfile_wb_ctrl
// Brief    : Writeback arbiter, write-port registers and busy scoreboard
// Revision : 1.0 - initial release
// ============================================================
module regfile_wb_ctrl #(
  parameter int NREQ = 3,
  parameter int AW   = regfile_pkg::AW,
  parameter int DW   = regfile_pkg::DW
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_wr,
  input  logic [NREQ*DW-1:0]   req_wd,
  output logic [NREQ-1:0]      req_ready,
  output logic [AW-1:0]        WR,
  output logic [DW-1:0]        WD,
  output logic                 WE,
  input  logic                 rsv_valid,
  input  logic [AW-1:0]        rsv_reg,
  output logic                 rsv_ready,
  input  logic [AW-1:0]        chk_r1,
  input  logic [AW-1:0]        chk_r2,
  output logic                 chk_busy1,
  output logic                 chk_busy2,
  output logic [31:0]          busy_vec,
  output logic                 err
);

  import regfile_pkg::*;

  logic [NREQ-1:0] grant;
  logic            xfer;

  logic [AW-1:0]   sel_wr;
  logic [DW-1:0]   sel_wd;

  logic            we_q,   we_d;
  logic [AW-1:0]   wr_q,   wr_d;
  logic [DW-1:0]   wd_q,   wd_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            err_q,  err_d;

  logic [NREG-1:0] rsv_set;
  logic [NREG-1:0] wb_clr;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk_i   (CLK),
    .rst_i   (RST),
    .valid_i (req_valid),
    .grant_o (grant),
    .xfer_o  (xfer)
  );

  always_comb begin
    sel_wr = '0;
    sel_wd = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (grant[j]) begin
        sel_wr = req_wr[j*AW +: AW];
        sel_wd = req_wd[j*DW +: DW];
      end
    end
  end

  assign rsv_ready = (rsv_reg == C_REG_ZERO) | ~busy_q[rsv_reg];

  // The clear is applied after the set so a same-cycle collision resolves to free.
  always_comb begin
    we_d    = xfer && (sel_wr != C_REG_ZERO);
    wr_d    = xfer ? sel_wr : wr_q;
    wd_d    = xfer ? sel_wd : wd_q;
    rsv_set = (rsv_valid && rsv_ready && (rsv_reg != C_REG_ZERO)) ? reg_onehot(rsv_reg) : '0;
    wb_clr  = we_q ? reg_onehot(wr_q) : '0;
    busy_d  = (busy_q | rsv_set) & ~wb_clr;
    busy_d[0] = 1'b0;
    err_d   = err_q | (we_q && (wr_q != C_REG_ZERO) && !busy_q[wr_q]);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      we_q   <= 1'b0;
      wr_q   <= '0;
      wd_q   <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      we_q   <= we_d;
      wr_q   <= wr_d;
      wd_q   <= wd_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign req_ready = grant;
  assign WE        = we_q;
  assign WR        = wr_q;
  assign WD        = wd_q;
  assign busy_vec  = busy_q;
  assign err       = err_q;
  assign chk_busy1 = busy_q[chk_r1];
  assign chk_busy2 = busy_q[chk_r2];

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_ctrl.sv
`default_nettype none
// ============================================================
// Module   : tb_regfile_wb_ctrl
// Brief    : Scoreboard bench for the writeback controller
// Revision : 1.0 - initial release
// ============================================================
module tb_regfile_wb_ctrl;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic              CLK = 1'b0;
  logic              RST;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*AW-1:0] req_wr;
  logic [NREQ*DW-1:0] req_wd;
  logic [NREQ-1:0]   req_ready;
  logic [AW-1:0]     WR;
  logic [DW-1:0]     WD;
  logic              WE;
  logic              rsv_valid;
  logic [AW-1:0]     rsv_reg;
  logic              rsv_ready;
  logic [AW-1:0]     chk_r1;
  logic [AW-1:0]     chk_r2;
  logic              chk_busy1;
  logic              chk_busy2;
  logic [31:0]       busy_vec;
  logic              err;

  always #5 CLK = ~CLK;

  regfile_wb_ctrl #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_valid (req_valid),
    .req_wr    (req_wr),
    .req_wd    (req_wd),
    .req_ready (req_ready),
    .WR        (WR),
    .WD        (WD),
    .WE        (WE),
    .rsv_valid (rsv_valid),
    .rsv_reg   (rsv_reg),
    .rsv_ready (rsv_ready),
    .chk_r1    (chk_r1),
    .chk_r2    (chk_r2),
    .chk_busy1 (chk_busy1),
    .chk_busy2 (chk_busy2),
    .busy_vec  (busy_vec),
    .err       (err)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] wr;
    logic [DW-1:0] wd;
    logic          err;
    logic [31:0]   busy;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_pass   = 0;

  int            m_ptr;
  logic [31:0]   m_busy;
  logic          m_err;
  logic          m_we;
  logic [AW-1:0] m_wr;
  logic [DW-1:0] m_wd;

  logic [NREQ-1:0] last_grant;
  logic            last_rsv_ready;

  task automatic model_reset();
    m_ptr  = 0;
    m_busy = '0;
    m_err  = 1'b0;
    m_we   = 1'b0;
    m_wr   = '0;
    m_wd   = '0;
    sb_q.delete();
  endtask

  task automatic clear_inputs();
    req_valid = '0;
    rsv_valid = 1'b0;
    rsv_reg   = '0;
    chk_r1    = '0;
    chk_r2    = '0;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] wr, input logic [DW-1:0] wd);
    req_valid[i]        = 1'b1;
    req_wr[i*AW +: AW]  = wr;
    req_wd[i*DW +: DW]  = wd;
  endtask

  // Called just after a falling edge with inputs set; predicts the next edge.
  task automatic drive_cycle();
    int          exp_win;
    int          idx;
    logic [31:0] n_busy;
    logic        rsv_ok;
    #1;
    last_grant     = req_ready;
    last_rsv_ready = rsv_ready;
    exp_win = -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_ptr + k) % NREQ;
      if (exp_win < 0 && req_valid[idx]) exp_win = idx;
    end
    rsv_ok = (rsv_reg == '0) || !m_busy[rsv_reg];
    n_busy = m_busy;
    if (rsv_valid && rsv_ok && rsv_reg != '0) n_busy[rsv_reg] = 1'b1;
    if (m_we) n_busy[m_wr] = 1'b0;
    if (m_we && m_wr != '0 && !m_busy[m_wr]) m_err = 1'b1;
    m_busy = n_busy;
    if (exp_win >= 0) begin
      m_wr  = req_wr[exp_win*AW +: AW];
      m_wd  = req_wd[exp_win*DW +: DW];
      m_we  = (m_wr != '0);
      m_ptr = (exp_win + 1) % NREQ;
    end else begin
      m_we = 1'b0;
    end
    sb_q.push_back('{m_we, m_wr, m_wd, m_err, m_busy});
    @(posedge CLK);
    @(negedge CLK);
    #2;
  endtask

  always @(negedge CLK) begin
    if (!RST && sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      n_checks++;
      if ({WE, WR, WD} !== {mon_e.we, mon_e.wr, mon_e.wd})
        $display("FAIL sb_write: got WE=%0b WR=%0d WD=%h, expected WE=%0b WR=%0d WD=%h",
                 WE, WR, WD, mon_e.we, mon_e.wr, mon_e.wd);
      else n_pass++;
      n_checks++;
      if (busy_vec !== mon_e.busy)
        $display("FAIL sb_busy: got %h expected %h", busy_vec, mon_e.busy);
      else n_pass++;
      n_checks++;
      if (err !== mon_e.err)
        $display("FAIL sb_err: got %0b expected %0b", err, mon_e.err);
      else n_pass++;
    end
  end

  task automatic test_reset();
    RST = 1'b1;
    clear_inputs();
    req_wr = '0;
    req_wd = '0;
    model_reset();
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    n_checks++;
    if ({WE, WR, WD} !== '0) $display("FAIL reset_wport: got WE=%0b WR=%0d WD=%h expected 0", WE, WR, WD);
    else n_pass++;
    n_checks++;
    if (busy_vec !== 32'h0 || err !== 1'b0) $display("FAIL reset_state: got busy=%h err=%0b expected 0/0", busy_vec, err);
    else n_pass++;
    n_checks++;
    if (req_ready !== 3'b000 || rsv_ready !== 1'b1)
      $display("FAIL reset_ready: got req_ready=%b rsv_ready=%0b expected 000/1", req_ready, rsv_ready);
    else n_pass++;
    #2;
    RST = 1'b0;
  endtask

  task automatic test_round_robin();
    int cnt [NREQ];
    for (int i = 0; i < NREQ; i++) begin
      clear_inputs();
      rsv_valid = 1'b1;
      rsv_reg   = AW'(i + 1);
      drive_cycle();
    end
    clear_inputs();
    for (int i = 0; i < NREQ; i++) begin
      cnt[i] = 0;
      set_req(i, AW'(i + 1), 32'hA000_0000 + i);
    end
    for (int c = 0; c < 9; c++) begin
      rsv_valid = (c >= 2 && c <= 7);
      rsv_reg   = AW'(((c + 1) % 3) + 1);
      drive_cycle();
      n_checks++;
      if (last_grant !== 3'(1 << (c % 3))) $display("FAIL rr_grant c=%0d: got %b expected %b", c, last_grant, 3'(1 << (c % 3)));
      else n_pass++;
      n_checks++;
      if (WE !== 1'b1) $display("FAIL rr_we c=%0d: got %0b expected 1", c, WE);
      else n_pass++;
      cnt[c % 3]++;
      req_wd[(c % 3)*DW +: DW] = 32'hA000_0000 + 32'(cnt[c % 3] * 16 + (c % 3));
    end
    clear_inputs();
    drive_cycle();
    drive_cycle();
    n_checks++;
    if (busy_vec !== 32'h0 || err !== 1'b0) $display("FAIL rr_drain: got busy=%h err=%0b expected 0/0", busy_vec, err);
    else n_pass++;
  endtask

  task automatic test_reserve_write_clear();
    clear_inputs();
    rsv_valid = 1'b1;
    rsv_reg   = 5'd5;
    drive_cycle();
    clear_inputs();
    chk_r1 = 5'd5;
    chk_r2 = 5'd6;
    #1;
    n_checks++;
    if (busy_vec[5] !== 1'b1 || chk_busy1 !== 1'b1 || chk_busy2 !== 1'b0)
      $display("FAIL rsv5_busy: got busy5=%0b chk1=%0b chk2=%0b expected 1/1/0", busy_vec[5], chk_busy1, chk_busy2);
    else n_pass++;
    set_req(0, 5'd5, 32'hDEADBEEF);
    drive_cycle();
    req_valid = '0;
    n_checks++;
    if ({WE, WR, WD} !== {1'b1, 5'd5, 32'hDEADBEEF})
      $display("FAIL wr5_port: got WE=%0b WR=%0d WD=%h expected 1/5/deadbeef", WE, WR, WD);
    else n_pass++;
    n_checks++;
    if (busy_vec[5] !== 1'b1) $display("FAIL wr5_busy_hold: got %0b expected 1", busy_vec[5]);
    else n_pass++;
    drive_cycle();
    n_checks++;
    if (busy_vec[5] !== 1'b0 || chk_busy1 !== 1'b0 || WE !== 1'b0)
      $display("FAIL wr5_clear: got busy5=%0b chk1=%0b WE=%0b expected 0/0/0", busy_vec[5], chk_busy1, WE);
    else n_pass++;
  endtask

  task automatic test_double_rsv();
    clear_inputs();
    rsv_valid = 1'b1;
    rsv_reg   = 5'd7;
    drive_cycle();
    n_checks++;
    if (last_rsv_ready !== 1'b1) $display("FAIL rsv7_first: got %0b expected 1", last_rsv_ready);
    else n_pass++;
    drive_cycle();
    n_checks++;
    if (last_rsv_ready !== 1'b0) $display("FAIL rsv7_second: got %0b expected 0", last_rsv_ready);
    else n_pass++;
    rsv_valid = 1'b0;
    set_req(2, 5'd7, 32'h0000_7777);
    drive_cycle();
    req_valid = '0;
    drive_cycle();
    n_checks++;
    if (last_rsv_ready !== 1'b0) $display("FAIL rsv7_during_we: got %0b expected 0", last_rsv_ready);
    else n_pass++;
    rsv_valid = 1'b1;
    drive_cycle();
    n_checks++;
    if (last_rsv_ready !== 1'b1) $display("FAIL rsv7_after_commit: got %0b expected 1", last_rsv_ready);
    else n_pass++;
    clear_inputs();
  endtask

  task automatic test_reg0();
    clear_inputs();
    rsv_valid = 1'b1;
    rsv_reg   = 5'd0;
    drive_cycle();
    n_checks++;
    if (last_rsv_ready !== 1'b1 || busy_vec !== 32'h0000_0080)
      $display("FAIL rsv0: got rsv_ready=%0b busy=%h expected 1/00000080", last_rsv_ready, busy_vec);
    else n_pass++;
    clear_inputs();
    set_req(1, 5'd0, 32'h1234_5678);
    drive_cycle();
    req_valid = '0;
    n_checks++;
    if (last_grant !== 3'b010) $display("FAIL wr0_grant: got %b expected 010", last_grant);
    else n_pass++;
    n_checks++;
    if (WE !== 1'b0 || WR !== 5'd0) $display("FAIL wr0_we: got WE=%0b WR=%0d expected 0/0", WE, WR);
    else n_pass++;
  endtask

  task automatic test_error();
    clear_inputs();
    set_req(1, 5'd9, 32'h0000_0099);
    drive_cycle();
    req_valid = '0;
    n_checks++;
    if (err !== 1'b0) $display("FAIL err_early: got %0b expected 0", err);
    else n_pass++;
    drive_cycle();
    n_checks++;
    if (err !== 1'b1) $display("FAIL err_set: got %0b expected 1", err);
    else n_pass++;
    drive_cycle();
    drive_cycle();
    n_checks++;
    if (err !== 1'b1) $display("FAIL err_sticky: got %0b expected 1", err);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    rsv_valid = 1'b1;
    rsv_reg = 5'd3; drive_cycle();
    rsv_reg = 5'd4; drive_cycle();
    rsv_reg = 5'd6; drive_cycle();
    clear_inputs();
    set_req(1, 5'd6, 32'h6666_0006);
    drive_cycle();
    n_checks++;
    if (WE !== 1'b1 || busy_vec !== 32'h0000_00D8)
      $display("FAIL mid_setup: got WE=%0b busy=%h expected 1/000000d8", WE, busy_vec);
    else n_pass++;
    req_valid = 3'b111;
    RST = 1'b1;
    #1;
    n_checks++;
    if (WE !== 1'b0 || busy_vec !== 32'h0 || err !== 1'b0)
      $display("FAIL mid_async: got WE=%0b busy=%h err=%0b expected 0/0/0", WE, busy_vec, err);
    else n_pass++;
    n_checks++;
    if (req_ready !== 3'b001) $display("FAIL mid_ptr: got req_ready=%b expected 001", req_ready);
    else n_pass++;
    @(posedge CLK);
    @(negedge CLK);
    #2;
    clear_inputs();
    model_reset();
    RST = 1'b0;
    set_req(2, 5'd0, 32'h0BAD_0000);
    drive_cycle();
    clear_inputs();
    n_checks++;
    if (last_grant !== 3'b100 || WE !== 1'b0) $display("FAIL post_reset: got grant=%b WE=%0b expected 100/0", last_grant, WE);
    else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_round_robin();
    test_reserve_write_clear();
    test_double_rsv();
    test_reg0();
    test_error();
    test_reset_mid();
    @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
